// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_oversampled
//  Description : 8N1 UART receiver. Synchronises the raw RX line, samples it
//                at OVERSAMPLE ticks per bit, recovers frames and presents
//                each good byte with a valid pulse and a held data-available
//                flag. Framing errors pulse; overrun is sticky until rd_ack.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_oversampled #(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_pin,
   input  logic       rd_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_data_available,
   output logic       rx_busy,
   output logic       framing_error,
   output logic       overrun
);

   // Clocks per sample tick (integer truncation is intentional)
   localparam int c_DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int c_TICK_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
   localparam int c_SC_W   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   // Sample-count values for mid start bit and for a full bit period
   localparam logic [c_SC_W-1:0]   c_SC_MID  = c_SC_W'(OVERSAMPLE / 2 - 1);
   localparam logic [c_SC_W-1:0]   c_SC_LAST = c_SC_W'(OVERSAMPLE - 1);
   localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(c_DIV - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } stateT;

   logic                r_syncA;
   logic                r_syncB;
   logic                r_rxPrev;
   logic                w_rxS;
   logic                w_fallEdge;
   logic                w_startDet;
   logic                w_tick;
   logic [c_TICK_W-1:0] r_tickCnt;
   stateT               r_state;
   logic [c_SC_W-1:0]   r_sampleCnt;
   logic [2:0]          r_bitIdx;
   logic [7:0]          r_shiftReg;
   logic [7:0]          r_rxData;
   logic                r_rxValid;
   logic                r_dataAvail;
   logic                r_busy;
   logic                r_frameErr;
   logic                r_overrun;

   // Two-flop synchroniser plus edge-detect flop; all reset to idle-high
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_syncA  <= 1'b1;
         r_syncB  <= 1'b1;
         r_rxPrev <= 1'b1;
      end else begin
         r_syncA  <= rx_pin;
         r_syncB  <= r_syncA;
         r_rxPrev <= r_syncB;
      end
   end

   assign w_rxS      = r_syncB;
   assign w_fallEdge = r_rxPrev & ~w_rxS;
   assign w_startDet = (r_state == IDLE) && w_fallEdge;
   // A start edge restarts the tick phase, so no tick may fire on that cycle
   assign w_tick     = (r_tickCnt == c_TICK_LAST) && !w_startDet;

   // Free-running sample-tick divider, re-phased on every accepted start edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tickCnt <= '0;
      end else if (w_startDet || (r_tickCnt == c_TICK_LAST)) begin
         r_tickCnt <= '0;
      end else begin
         r_tickCnt <= r_tickCnt + c_TICK_W'(1);
      end
   end

   // Frame recovery FSM with registered byte, pulses and status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_sampleCnt <= '0;
         r_bitIdx    <= 3'd0;
         r_shiftReg  <= 8'h00;
         r_rxData    <= 8'h00;
         r_rxValid   <= 1'b0;
         r_dataAvail <= 1'b0;
         r_busy      <= 1'b0;
         r_frameErr  <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_rxValid  <= 1'b0;
         r_frameErr <= 1'b0;

         // Consumer acknowledge; a late good byte below overrides the clear
         if (rd_ack && r_dataAvail) begin
            r_dataAvail <= 1'b0;
            r_overrun   <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (w_fallEdge) begin
                  r_sampleCnt <= '0;
                  r_state     <= START;
                  r_busy      <= 1'b1;
               end
            end

            START: begin
               if (w_tick) begin
                  if (r_sampleCnt == c_SC_MID) begin
                     if (!w_rxS) begin
                        r_sampleCnt <= '0;
                        r_bitIdx    <= 3'd0;
                        r_state     <= DATA;
                     end else begin
                        // Line back high at mid start bit: glitch, no flag
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_sampleCnt <= r_sampleCnt + c_SC_W'(1);
                  end
               end
            end

            DATA: begin
               if (w_tick) begin
                  if (r_sampleCnt == c_SC_LAST) begin
                     r_shiftReg  <= {w_rxS, r_shiftReg[7:1]};
                     r_sampleCnt <= '0;
                     if (r_bitIdx == 3'd7) begin
                        r_state <= STOP;
                     end else begin
                        r_bitIdx <= r_bitIdx + 3'd1;
                     end
                  end else begin
                     r_sampleCnt <= r_sampleCnt + c_SC_W'(1);
                  end
               end
            end

            STOP: begin
               if (w_tick) begin
                  if (r_sampleCnt == c_SC_LAST) begin
                     if (w_rxS) begin
                        r_rxData    <= r_shiftReg;
                        r_rxValid   <= 1'b1;
                        r_dataAvail <= 1'b1;
                        if (r_dataAvail && !rd_ack) begin
                           r_overrun <= 1'b1;
                        end
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_frameErr <= 1'b1;
                        r_state    <= WAIT_IDLE;
                     end
                  end else begin
                     r_sampleCnt <= r_sampleCnt + c_SC_W'(1);
                  end
               end
            end

            WAIT_IDLE: begin
               // Break or stuck-low line: hold off new starts until it rises
               if (w_rxS) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end

            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_data           = r_rxData;
   assign rx_valid          = r_rxValid;
   assign rx_data_available = r_dataAvail;
   assign rx_busy           = r_busy;
   assign framing_error     = r_frameErr;
   assign overrun           = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_oversampled
//  Description : Directed self-checking bench for uart_rx_oversampled, run at
//                a scaled line rate (5 clocks per tick, 80 clocks per bit).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_oversampled;

   localparam int c_CLK_FREQ = 8000000;
   localparam int c_BAUD     = 100000;
   localparam int c_BIT      = 80;              // clocks per bit = 5 * 16
   localparam int c_LAT      = 152 * 5;          // 9.5 bit times in clocks

   logic       clk;
   logic       reset;
   logic       rx_pin;
   logic       rd_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_data_available;
   logic       rx_busy;
   logic       framing_error;
   logic       overrun;

   int passCnt      = 0;
   int totalCnt     = 0;
   int cyc          = 0;
   int validCnt     = 0;
   int feCnt        = 0;
   int lastValidCyc = 0;
   int startCyc     = 0;
   int snapValid    = 0;
   int snapFe       = 0;
   int lat          = 0;

   uart_rx_oversampled #(
      .CLK_FREQ   (c_CLK_FREQ),
      .BAUD       (c_BAUD),
      .OVERSAMPLE (16)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .rx_pin            (rx_pin),
      .rd_ack            (rd_ack),
      .rx_data           (rx_data),
      .rx_valid          (rx_valid),
      .rx_data_available (rx_data_available),
      .rx_busy           (rx_busy),
      .framing_error     (framing_error),
      .overrun           (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse monitor sampled on the falling edge
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rx_valid) begin
         validCnt     = validCnt + 1;
         lastValidCyc = cyc;
      end
      if (framing_error) feCnt = feCnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic sendFrame(input logic [7:0] d, input logic stopBit);
      @(negedge clk);
      rx_pin   = 1'b0;
      startCyc = cyc;
      repeat (c_BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_pin = d[i];
         repeat (c_BIT) @(negedge clk);
      end
      rx_pin = stopBit;
      repeat (c_BIT) @(negedge clk);
   endtask

   task automatic pulseAck();
      @(negedge clk);
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset  = 1'b1;
      rx_pin = 1'b1;
      rd_ack = 1'b0;

      // Reset state
      #80;
      @(negedge clk);
      check("rst_data",  {24'd0, rx_data}, 32'h00);
      check("rst_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_avail", {31'd0, rx_data_available}, 32'd0);
      check("rst_busy",  {31'd0, rx_busy}, 32'd0);
      check("rst_ferr",  {31'd0, framing_error}, 32'd0);
      check("rst_ovr",   {31'd0, overrun}, 32'd0);
      reset = 1'b0;

      // Idle line: no activity
      repeat (2000) @(negedge clk);
      check("idle_valid", validCnt, 0);
      check("idle_ferr",  feCnt, 0);
      check("idle_busy",  {31'd0, rx_busy}, 32'd0);

      // Good byte 0xA5
      sendFrame(8'hA5, 1'b1);
      lat = lastValidCyc - startCyc;
      check("a5_count", validCnt, 1);
      check("a5_data",  {24'd0, rx_data}, 32'hA5);
      check("a5_avail", {31'd0, rx_data_available}, 32'd1);
      check("a5_lat",   {31'd0, (lat >= c_LAT) && (lat <= c_LAT + 6)}, 32'd1);
      check("a5_ovr",   {31'd0, overrun}, 32'd0);
      pulseAck();
      check("a5_ack_avail", {31'd0, rx_data_available}, 32'd0);

      // Short low glitch on an idle line
      @(negedge clk);
      rx_pin = 1'b0;
      repeat (15) @(negedge clk);
      check("gl_busy_hi", {31'd0, rx_busy}, 32'd1);
      rx_pin = 1'b1;
      repeat (100) @(negedge clk);
      check("gl_busy_lo", {31'd0, rx_busy}, 32'd0);
      check("gl_valid",   validCnt, 1);
      check("gl_ferr",    feCnt, 0);

      // 0x3C with a low stop bit, line then held low three bit times
      sendFrame(8'h3C, 1'b0);
      repeat (3 * c_BIT) @(negedge clk);
      check("fe_count", feCnt, 1);
      check("fe_data",  {24'd0, rx_data}, 32'hA5);
      check("fe_valid", validCnt, 1);
      check("fe_avail", {31'd0, rx_data_available}, 32'd0);
      check("fe_busy",  {31'd0, rx_busy}, 32'd1);
      rx_pin = 1'b1;
      repeat (10) @(negedge clk);
      check("fe_busy_lo", {31'd0, rx_busy}, 32'd0);

      // Two bytes without acknowledge -> overrun
      sendFrame(8'h11, 1'b1);
      check("ov_first_ovr", {31'd0, overrun}, 32'd0);
      sendFrame(8'h22, 1'b1);
      check("ov_count", validCnt, 3);
      check("ov_data",  {24'd0, rx_data}, 32'h22);
      check("ov_avail", {31'd0, rx_data_available}, 32'd1);
      check("ov_flag",  {31'd0, overrun}, 32'd1);
      pulseAck();
      check("ov_ack_flag",  {31'd0, overrun}, 32'd0);
      check("ov_ack_avail", {31'd0, rx_data_available}, 32'd0);

      // Reset in the middle of data bit 4 of 0xFF
      snapValid = validCnt;
      snapFe    = feCnt;
      @(negedge clk);
      rx_pin = 1'b0;
      repeat (c_BIT) @(negedge clk);
      rx_pin = 1'b1;
      repeat (4 * c_BIT + c_BIT / 2) @(negedge clk);
      check("mr_busy_pre", {31'd0, rx_busy}, 32'd1);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("mr_busy", {31'd0, rx_busy}, 32'd0);
      check("mr_data", {24'd0, rx_data}, 32'h00);
      repeat (6 * c_BIT) @(negedge clk);
      check("mr_quiet", validCnt, snapValid);
      sendFrame(8'h5A, 1'b1);
      check("mr_count", validCnt, snapValid + 1);
      check("mr_data5a", {24'd0, rx_data}, 32'h5A);
      check("mr_avail", {31'd0, rx_data_available}, 32'd1);
      check("mr_ferr", feCnt, snapFe);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
UART receiver front end that feeds the main datapath with command/operand bytes from the board's RX pin. It synchronises the asynchronous line, oversamples it 16x, recovers 8N1 frames, and presents each byte with a valid pulse and a held data-available flag. The flag drives the datapath's data-available LED and its fetch logic. Framing and overrun errors are flagged for the debug LEDs.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s
OVERSAMPLE, 16, sample ticks per bit
DIV, CLK_FREQ/(BAUD*OVERSAMPLE) = 651, clocks per sample tick (localparam, integer truncation)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
rx_pin  input  1  raw UART line, idle high, asynchronous to clk
rd_ack  input  1  consumer pulse: byte taken, clears rx_data_available
rx_data  output  8  last good byte, LSB received first
rx_valid  output  1  one-cycle pulse when a good byte is loaded into rx_data
rx_data_available  output  1  level, set with rx_valid, cleared by rd_ack
rx_busy  output  1  high whenever state is not IDLE
framing_error  output  1  one-cycle pulse on a bad stop bit
overrun  output  1  sticky, set when a byte overwrites an unacknowledged byte

Behaviour:
- Reset (async, active-high) values: rx_data=8'h00, all flags 0, state IDLE, counters 0. Both synchroniser flops reset to 1 (idle line).
- Input path: 2-FF synchroniser, then rx_s. Edge detect uses a third flop.
- Tick generator: counter 0..DIV-1, with tick=1 for one cycle at DIV-1. It is forced to 0 on the cycle a start edge is detected, so sampling is phase-aligned to the edge.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on a falling edge of rx_s, clear the tick counter and sample counter (sc), then go to START.
- START: count ticks. At sc=7 (mid start bit), if rx_s=0, clear sc and bit index and go to DATA. If rx_s=1, treat it as a glitch and return to IDLE with no flag.
- DATA: at sc=15, shift rx_s into shift register MSB with right shift (LSB first) and clear sc. After bit index 7, go to STOP.
- STOP: at sc=15 (mid stop bit), if rx_s=1, load rx_data, pulse rx_valid, set rx_data_available and go to IDLE. If rx_s=0, pulse framing_error, leave rx_data unchanged and go to WAIT_IDLE.
- WAIT_IDLE (break/line stuck low): stay until rx_s=1, then go to IDLE. No new start is accepted until then.
- Latency: rx_valid asserts 2 sync cycles plus 8+8*16+16 ticks (9.5 bit times) after the start edge. The data/flag update happens on the tick cycle.
- rx_data_available: set on a good byte, cleared on rd_ack. rd_ack while the flag is 0 is ignored.
- Good byte completes in the same cycle as rd_ack: the flag stays 1 with new data, and overrun is not set.
- overrun: set when a good byte completes while rx_data_available=1 and rd_ack=0. New data still overwrites rx_data. overrun clears only on rd_ack or reset.
- rx_busy = (state != IDLE), registered with the state.
- Reset mid-frame returns to IDLE immediately. The partial byte is discarded and no flags are raised after release.

Test Plan:
- Reset 80 ns with rx_pin=1 -> all outputs 0, rx_busy=0. After release, holding rx_pin=1 for 20000 clocks -> no activity.
- Send 8'hA5 at 9600 baud (10416 clocks/bit) -> rx_valid one-cycle pulse ~98950 clocks after start edge, rx_data=8'hA5, rx_data_available=1. Then rd_ack pulse -> rx_data_available=0.
- 2000-clock low glitch on idle line -> returns to IDLE from START, rx_valid/framing_error never assert, rx_busy falls within 5300 clocks.
- Frame 8'h3C with stop bit driven 0 and line then held low 3 bit times -> framing_error pulse, rx_data keeps its previous value, rx_busy high until rx_pin returns 1.
- Send 8'h11 then 8'h22 without rd_ack -> overrun=1, rx_data=8'h22. rd_ack -> overrun=0 and rx_data_available=0.
- Assert reset during data bit 4 of 8'hFF, release, then send 8'h5A -> only 8'h5A is received, with exactly one rx_valid.
